charge_balance_encoder: RTL and testbench
=========================================

Name: charge_balance_encoder

Overview:
Transmit-side counterpart to the nibble charge detector. Accepts 4-bit data words over a valid/ready handshake and encodes each into a 5-bit DC-balanced symbol: the nibble plus an invert flag, with the flag chosen to drive the running charge (disparity) toward zero. Serialises each symbol LSB first onto a single line. The receiving side uses charge detection plus the flag to recover data and check balance.

Parameters:
RD_W, 4, width of the signed running-disparity register (holds -5..+4; must be ≥4)
IDLE_LEVEL, 0, value driven on tx_bit when no symbol is being shifted

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  4  data nibble to encode
in_valid  input  1  in_data valid
in_ready  output  1  encoder can accept a nibble this cycle
tx_bit  output  1  serial symbol bit
tx_valid  output  1  tx_bit carries a symbol bit
tx_start  output  1  pulses with bit 0 of each symbol
rd_out  output  RD_W  current running disparity, signed two's complement
sym_out  output  5  last chosen symbol {flag, nibble'}, held until next accept

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: in_ready=1, tx_bit=IDLE_LEVEL, tx_valid=0, tx_start=0, rd_out=0, sym_out=0, state=IDLE, bit_cnt=0.
- Disparity of a 5-bit symbol: d = 2*popcount(symbol) - 5. Always odd, range -5..+5.
- Encoding on accept (in_valid & in_ready):
  - d_plain = disparity of {1'b0, in_data}.
  - RD ≥ 0 counts as positive.
  - If sign(d_plain) equals sign(RD), choose the inverted symbol {1'b1, ~in_data} (d = -d_plain). Otherwise choose the plain symbol {1'b0, in_data}.
  - RD_next = RD + d_chosen. RD stays within -5..+4 by construction. No saturation logic is needed.
  - rd_out and sym_out update on the accept edge.
- FSM:
  - IDLE: in_ready=1. On accept, load the shift register and go to SHIFT with bit_cnt=0.
  - SHIFT: tx_valid=1. tx_bit = symbol[bit_cnt]; bit 0 first, flag (bit 4) last. tx_start=1 only when bit_cnt=0. bit_cnt increments each cycle.
  - SHIFT exit: at bit_cnt=4, in_ready=1.
    - Accept in that cycle: reload and stay in SHIFT with bit_cnt=0, giving gapless back-to-back symbols.
    - No accept: go to IDLE.
  - in_ready=0 for bit_cnt 0..3.
- Latency: nibble accepted at edge N; bit 0 appears on tx_bit in the cycle following edge N. A symbol occupies exactly 5 tx_valid cycles. Sustained throughput is 1 nibble per 5 cycles.
- in_valid without in_ready is ignored. in_data is not captured, and RD is unchanged.
- Reset mid-symbol: the symbol is aborted. Outputs take reset values at the next edge, and RD returns to 0. An in_valid asserted together with rst is not accepted.
- tx_bit equals IDLE_LEVEL whenever tx_valid=0.

Test Plan:
- After reset, send 4'b1111: d_plain=+3 and RD=0 (positive), so inverted. sym_out=5'b10000, tx_bit sequence 0,0,0,0,1 with tx_start on first bit, rd_out=-3.
- Then send 4'b0000: d_plain=-5 and RD<0, so inverted. sym_out=5'b11111, bits 1,1,1,1,1, rd_out=+2.
- Then send 4'b0110: d_plain=-1 and RD=+2, so plain. sym_out=5'b00110, bits 0,1,1,0,0, rd_out=+1.
- Back-to-back: hold in_valid=1 with 3 nibbles. in_ready pulses only on the 5th bit of each symbol. tx_valid stays high for 15 consecutive cycles, with tx_start every 5 cycles.
- Hold-off: assert in_valid with 4'b1010 while bit_cnt=1. The word is not accepted, and RD and sym_out are unchanged until the bit_cnt=4 cycle.
- Reset during bit 2 of a symbol: next cycle tx_valid=0, tx_bit=IDLE_LEVEL, rd_out=0, in_ready=1. A following 4'b1111 encodes exactly as in scenario 1.

Source files
------------

// File: rtl/charge_balance_encoder.sv
// DC-balanced nibble encoder: each accepted nibble becomes a 5-bit symbol {flag, nibble'}
// chosen to pull the running disparity toward zero, then shifted out LSB first.
module charge_balance_encoder #(
  parameter int   RD_W       = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx_bit,
  output logic                   tx_valid,
  output logic                   tx_start,
  output logic signed [RD_W-1:0] rd_out,
  output logic [4:0]             sym_out
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'd4;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [4:0] shreg;

  logic                   accept;
  logic                   plain_pos;
  logic                   rd_pos;
  logic [4:0]             enc_sym;
  logic signed [RD_W-1:0] d_chosen;
  logic signed [RD_W-1:0] rd_next;
  logic [2:0]             next_cnt;

  // Disparity of a 5-bit symbol: 2*ones - 5, always odd, -5..+5.
  function automatic logic signed [RD_W-1:0] disparity(input logic [4:0] s);
    int ones;
    int d;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) ones++;
    end
    d = 2 * ones - 5;
    return d[RD_W-1:0];
  endfunction

  // in_ready is registered and only high in IDLE or on the last symbol bit,
  // so an accept can never interrupt a symbol mid-flight.
  assign accept = in_valid & in_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    plain_pos = 1'b0;
    rd_pos    = 1'b0;
    enc_sym   = {1'b0, in_data};
    d_chosen  = '0;
    rd_next   = rd_out;
    next_cnt  = bit_cnt + 3'd1;

    // A plain nibble has positive disparity when three or more bits are set;
    // zero running disparity counts as positive.
    plain_pos = (disparity({1'b0, in_data}) > 0);
    rd_pos    = ~rd_out[RD_W-1];
    if (plain_pos == rd_pos) begin
      enc_sym = {1'b1, ~in_data};
    end
    d_chosen = disparity(enc_sym);
    rd_next  = rd_out + d_chosen;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      in_ready <= 1'b1;
      tx_bit   <= IDLE_LEVEL;
      tx_valid <= 1'b0;
      tx_start <= 1'b0;
      rd_out   <= '0;
      sym_out  <= '0;
    end else if (accept) begin
      // Same path from IDLE and from the last bit of SHIFT: gapless reload.
      state    <= SHIFT;
      bit_cnt  <= '0;
      shreg    <= enc_sym;
      sym_out  <= enc_sym;
      rd_out   <= rd_next;
      tx_valid <= 1'b1;
      tx_bit   <= enc_sym[0];
      tx_start <= 1'b1;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          tx_valid <= 1'b0;
          tx_bit   <= IDLE_LEVEL;
          tx_start <= 1'b0;
        end
        SHIFT: begin
          tx_start <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_valid <= 1'b0;
            tx_bit   <= IDLE_LEVEL;
            in_ready <= 1'b1;
          end else begin
            bit_cnt  <= next_cnt;
            tx_valid <= 1'b1;
            tx_bit   <= shreg[next_cnt];
            in_ready <= (next_cnt == LAST_BIT);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charge_balance_encoder.sv
// Self-checking bench for charge_balance_encoder: directed scenarios plus random traffic,
// compared every cycle against a symbol-level queue model of the serial line.
module tb_charge_balance_encoder;

  localparam int   RD_W = 4;
  localparam logic IDLE = 1'b0;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   tx_bit;
  logic                   tx_valid;
  logic                   tx_start;
  logic signed [RD_W-1:0] rd_out;
  logic [4:0]             sym_out;

  charge_balance_encoder #(
    .RD_W      (RD_W),
    .IDLE_LEVEL(IDLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_bit  (tx_bit),
    .tx_valid(tx_valid),
    .tx_start(tx_start),
    .rd_out  (rd_out),
    .sym_out (sym_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the serial line as a queue of pending bits, plus running disparity.
  typedef struct {
    logic b;
    logic first;
  } line_bit_t;

  line_bit_t  q[$];
  int         m_rd;
  logic [4:0] m_sym;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [4:0] encode(input logic [3:0] n, input int rd);
    int dp;
    dp = 2 * $countones(n) - 5;
    if ((dp > 0) == (rd >= 0)) return {1'b1, ~n};
    return {1'b0, n};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Check current outputs against the model, drive inputs, advance one clock, update model.
  task automatic cycle(input logic r, input logic v, input logic [3:0] d, output bit acc);
    bit         exp_ready;
    logic [4:0] s;
    exp_ready = (q.size() <= 1);
    check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    check("tx_bit",   32'(tx_bit),   32'((q.size() != 0) ? q[0].b : IDLE));
    check("tx_start", 32'(tx_start), 32'((q.size() != 0) ? q[0].first : 1'b0));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("rd_out",   32'(rd_out),   32'(m_rd));
    check("sym_out",  32'(sym_out),  32'(m_sym));
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (r) begin
      q.delete();
      m_rd  = 0;
      m_sym = '0;
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (v && exp_ready) begin
        acc = 1'b1;
        s   = encode(d, m_rd);
        for (int i = 0; i < 5; i++) q.push_back('{b: s[i], first: (i == 0)});
        m_rd  = m_rd + 2 * $countones(s) - 5;
        m_sym = s;
      end
    end
  endtask

  initial begin
    bit         acc;
    int         idx;
    int         hi_cnt;
    int         start_cnt;
    int         ready_cnt;
    logic [3:0] words[3];

    // Reset with in_valid high: the word must not be accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    q.delete();
    m_rd  = 0;
    m_sym = '0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_tx_valid", 32'(tx_valid), 32'(0));
    check("reset_tx_bit",   32'(tx_bit),   32'(IDLE));
    check("reset_rd",       32'(rd_out),   32'(0));
    check("reset_sym",      32'(sym_out),  32'(0));

    // Scenario 1: 1111 -> inverted 10000, rd -3.
    cycle(1'b0, 1'b1, 4'b1111, acc);
    check("s1_accept", 32'(acc), 32'(1));
    repeat (5) cycle(1'b0, 1'b0, 4'h0, acc);
    check("s1_sym", 32'(sym_out), 32'(5'b10000));
    check("s1_rd",  32'(rd_out),  32'(-3));

    // Scenario 2: 0000 -> inverted 11111, rd +2.
    cycle(1'b0, 1'b1, 4'b0000, acc);
    repeat (5) cycle(1'b0, 1'b0, 4'h0, acc);
    check("s2_sym", 32'(sym_out), 32'(5'b11111));
    check("s2_rd",  32'(rd_out),  32'(2));

    // Scenario 3: 0110 -> plain 00110, rd +1.
    cycle(1'b0, 1'b1, 4'b0110, acc);
    repeat (5) cycle(1'b0, 1'b0, 4'h0, acc);
    check("s3_sym", 32'(sym_out), 32'(5'b00110));
    check("s3_rd",  32'(rd_out),  32'(1));

    // Back-to-back: three nibbles with in_valid held high.
    words = '{4'h3, 4'hC, 4'h9};
    cycle(1'b0, 1'b1, words[0], acc);
    idx       = 1;
    hi_cnt    = 0;
    start_cnt = 0;
    ready_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (tx_valid) hi_cnt++;
      if (tx_start) start_cnt++;
      if (in_ready) ready_cnt++;
      cycle(1'b0, idx < 3, words[(idx < 3) ? idx : 0], acc);
      if (acc) idx++;
    end
    check("b2b_valid_run", 32'(hi_cnt),    32'(15));
    check("b2b_starts",    32'(start_cnt), 32'(3));
    check("b2b_ready",     32'(ready_cnt), 32'(3));
    check("b2b_idle_after", 32'(tx_valid), 32'(0));

    // Hold-off: 1010 offered from bit 1 on, taken only at the last bit.
    cycle(1'b0, 1'b1, 4'h5, acc);
    cycle(1'b0, 1'b0, 4'h0, acc);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 4'b1010, acc);
      check("hold_not_taken", 32'(acc), 32'(0));
    end
    cycle(1'b0, 1'b1, 4'b1010, acc);
    check("hold_taken_last", 32'(acc), 32'(1));
    repeat (5) cycle(1'b0, 1'b0, 4'h0, acc);

    // Reset during bit 2, then 1111 encodes as after the first reset.
    cycle(1'b0, 1'b1, 4'h7, acc);
    cycle(1'b0, 1'b0, 4'h0, acc);
    cycle(1'b0, 1'b0, 4'h0, acc);
    cycle(1'b1, 1'b1, 4'h2, acc);
    check("rst_mid_valid", 32'(tx_valid), 32'(0));
    check("rst_mid_bit",   32'(tx_bit),   32'(IDLE));
    check("rst_mid_rd",    32'(rd_out),   32'(0));
    check("rst_mid_ready", 32'(in_ready), 32'(1));
    cycle(1'b0, 1'b1, 4'b1111, acc);
    repeat (5) cycle(1'b0, 1'b0, 4'h0, acc);
    check("rst_s1_sym", 32'(sym_out), 32'(5'b10000));
    check("rst_s1_rd",  32'(rd_out),  32'(-3));

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 4'($urandom), acc);
    end
    cycle(1'b0, 1'b0, 4'h0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
